// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game blocks: state encodings, screen size
// and the default pipe slot geometry used by both the controller and pipe generator.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SLOT_W   = 100;
  localparam int SLOT_H   = 100;

endpackage

// File: rtl/bird_ctrl_btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// rising-edge detector producing a one-cycle pulse.
module btn_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/bird_ctrl.sv
// Game-state FSM, bird vertical physics and pipe/ground collision on the 2 ms tick.
// Optional build macro GOD_MODE_EN: pipe collisions ignored, only ground contact ends the game.
module bird_ctrl #(
  parameter int SLOT_W   = flappy_pkg::SLOT_W,
  parameter int SLOT_H   = flappy_pkg::SLOT_H,
  parameter int BIRD_XL  = 286,
  parameter int BIRD_XR  = 320,
  parameter int BIRD_H   = 24,
  parameter int BIRD_Y0  = 228,
  parameter int PHYS_DIV = 8,
  parameter int FLAP_V   = 6,
  parameter int VMAX     = 8,
  parameter int LOCKOUT  = 250
) (
  input  logic              clk_2ms,
  input  logic              rst,
  input  logic              btn_flap,
  input  logic [9:0]        pip_X,
  input  logic [8:0]        pip_Y,
  output logic [1:0]        state,
  output logic [8:0]        bird_Y,
  output logic signed [5:0] bird_vel,
  output logic              crash
);
  import flappy_pkg::*;

  localparam int                DIV_W    = (PHYS_DIV > 1) ? $clog2(PHYS_DIV) : 1;
  localparam int                LK_W     = $clog2(LOCKOUT + 1);
  localparam logic [8:0]        Y_INIT   = 9'(BIRD_Y0);
  localparam logic signed [5:0] VEL_FLAP = 6'(-FLAP_V);
  localparam logic signed [6:0] VMAX_S   = 7'(VMAX);
  localparam logic signed [10:0] Y_MAX_S = 11'(SCREEN_H - BIRD_H);

  function automatic logic [8:0] clamp_y(input logic signed [10:0] s);
    if (s < 11'sd0) return 9'd0;
    if (s > Y_MAX_S) return Y_MAX_S[8:0];
    return s[8:0];
  endfunction

  function automatic logic signed [5:0] sat_vel(input logic signed [5:0] v);
    logic signed [6:0] n;
    n = {v[5], v} + 7'sd1;
    if (n > VMAX_S) return VMAX_S[5:0];
    if (n > 7'sd31) return 6'sd31;
    return n[5:0];
  endfunction

  state_e            state_q;
  logic [8:0]        y_q;
  logic signed [5:0] vel_q;
  logic [DIV_W-1:0]  div_q;
  logic [LK_W-1:0]   lock_q;
  logic              crash_q;

  logic              flap;
  logic              step;
  logic              ground;
  logic              hit;
  logic signed [10:0] y_sum;
  logic [8:0]        y_d;
  logic signed [5:0] vel_d;

  btn_edge_sync u_sync (
    .clk_i   (clk_2ms),
    .rst_i   (rst),
    .d_i     (btn_flap),
    .pulse_o (flap)
  );

  assign step   = (div_q == DIV_W'(PHYS_DIV - 1));
  assign y_sum  = $signed({2'b00, y_q}) + $signed({{5{vel_q[5]}}, vel_q});
  assign y_d    = clamp_y(y_sum);
  assign vel_d  = sat_vel(vel_q);
  assign ground = ({2'b00, y_q} >= Y_MAX_S);

`ifdef GOD_MODE_EN
  assign hit = ground;
`else
  // 11-bit unsigned compares keep pipes that are partly off the left edge correct.
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] yb;
  logic        x_ov;
  logic        y_out;
  assign px    = {1'b0, pip_X};
  assign py    = {2'b00, pip_Y};
  assign yb    = {2'b00, y_q};
  assign x_ov  = (px > 11'(BIRD_XL)) && (px < 11'(BIRD_XR + SLOT_W));
  assign y_out = ((yb + 11'(SLOT_H)) < py) || ((yb + 11'(BIRD_H)) > py);
  assign hit   = (x_ov && y_out) || ground;
`endif

  always_ff @(posedge clk_2ms) begin
    if (rst) begin
      state_q <= ST_READY;
      y_q     <= Y_INIT;
      vel_q   <= '0;
      div_q   <= '0;
      lock_q  <= '0;
      crash_q <= 1'b0;
    end else begin
      crash_q <= 1'b0;
      case (state_q)
        ST_READY: begin
          y_q    <= Y_INIT;
          vel_q  <= '0;
          div_q  <= '0;
          lock_q <= '0;
          if (flap) begin
            state_q <= ST_PLAY;
            vel_q   <= VEL_FLAP;
          end
        end
        ST_PLAY: begin
          if (hit) begin
            state_q <= ST_OVER;
            crash_q <= 1'b1;
          end else begin
            div_q <= step ? '0 : div_q + DIV_W'(1);
            if (step) y_q <= y_d;
            // A flap wins over gravity; the position step still uses the old velocity.
            if (flap) vel_q <= VEL_FLAP;
            else if (step) vel_q <= vel_d;
          end
        end
        ST_OVER: begin
          if (lock_q == LK_W'(LOCKOUT)) begin
            if (flap) begin
              state_q <= ST_READY;
              y_q     <= Y_INIT;
              vel_q   <= '0;
              div_q   <= '0;
              lock_q  <= '0;
            end
          end else begin
            lock_q <= lock_q + LK_W'(1);
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  assign state    = state_q;
  assign bird_Y   = y_q;
  assign bird_vel = vel_q;
  assign crash    = crash_q;

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed bench for bird_ctrl: flap latency, physics, pipe/ground hits,
// lockout and reset. Honours GOD_MODE_EN for the pipe-hit expectations.
module tb_bird_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              btn_flap;
  logic [9:0]        pip_X;
  logic [8:0]        pip_Y;
  logic [1:0]        state;
  logic [8:0]        bird_Y;
  logic signed [5:0] bird_vel;
  logic              crash;

`ifdef GOD_MODE_EN
  localparam int GM = 1;
`else
  localparam int GM = 0;
`endif
  localparam int HIT_ST = GM ? 1 : 2;

  int n_chk  = 0;
  int n_pass = 0;
  bit auto_flap = 1'b0;
  int ph = 0;
  int n;

  bird_ctrl dut (
    .clk_2ms  (clk),
    .rst      (rst),
    .btn_flap (btn_flap),
    .pip_X    (pip_X),
    .pip_Y    (pip_Y),
    .state    (state),
    .bird_Y   (bird_Y),
    .bird_vel (bird_vel),
    .crash    (crash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance cycles; button is driven at the falling edge, outputs sampled there too.
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
      if (auto_flap) begin
        btn_flap = ((ph % 8) < 4);
        ph++;
      end
    end
  endtask

  // Square-wave button, period 8: one flap every physics step, aligned with it.
  task automatic start_auto();
    auto_flap = 1'b1;
    btn_flap  = 1'b1;
    ph        = 1;
  endtask

  task automatic stop_auto();
    auto_flap = 1'b0;
    btn_flap  = 1'b0;
  endtask

  task automatic wait_y(input int target, input int limit, output int cnt);
    cnt = 0;
    while (bird_Y !== 9'(target) && cnt < limit) begin
      cyc(1);
      cnt++;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_flap = 1'b0; pip_X = 10'd0; pip_Y = 9'd0;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_y", bird_Y, 228);
    chk("rst_vel", bird_vel, 0);
    chk("rst_crash", crash, 0);
    rst = 1'b0;
    cyc(20);
    chk("ready_hold_state", state, 0);
    chk("ready_hold_y", bird_Y, 228);

    // Game A: continuous flapping climbs 6 px per step up to the ceiling.
    start_auto();
    cyc(2);
    chk("flap_lat2_state", state, 0);
    cyc(1);
    chk("flap_lat3_state", state, 1);
    chk("flap_vel", bird_vel, -6);
    chk("flap_y", bird_Y, 228);
    cyc(8);
    chk("climb_step1_y", bird_Y, 222);
    chk("climb_step1_vel", bird_vel, -6);
    pip_X = 10'd300; pip_Y = 9'd300;
    cyc(3);
    chk("in_gap_state", state, 1);
    pip_X = 10'd0;
    wait_y(0, 400, n);
    chk("climb_to_0_cycles", n, 293);
    cyc(8);
    chk("ceiling_y", bird_Y, 0);
    chk("ceiling_state", state, 1);
    pip_X = 10'd420; pip_Y = 9'd300;
    cyc(2);
    chk("px420_state", state, 1);
    pip_X = 10'd286;
    cyc(2);
    chk("px286_state", state, 1);
    pip_X = 10'd287;
    cyc(1);
    chk("px287_state", state, HIT_ST);
    chk("px287_crash", crash, GM ? 0 : 1);
    stop_auto();
    pip_X = 10'd0;
    pulse_rst();
    chk("rstA_state", state, 0);

    // Game B: climb to y=150, top of bird above the gap.
    start_auto();
    cyc(3);
    chk("gameB_state", state, 1);
    wait_y(150, 200, n);
    chk("climb_to_150_cycles", n, 104);
    chk("y150_vel", bird_vel, -6);
    pip_X = 10'd300; pip_Y = 9'd300;
    cyc(1);
    chk("above_gap_state", state, HIT_ST);
    stop_auto();
    pip_X = 10'd0;
    pulse_rst();

    // Game C: single flap then free fall to the ground.
    btn_flap = 1'b1;
    cyc(3);
    chk("gameC_state", state, 1);
    cyc(8);
    chk("single_step1_y", bird_Y, 222);
    chk("single_step1_vel", bird_vel, -5);
    btn_flap = 1'b0;
    cyc(112);
    chk("step15_y", bird_Y, 243);
    chk("step15_vel", bird_vel, 8);
    cyc(8);
    chk("step16_y", bird_Y, 251);
    chk("vel_sat", bird_vel, 8);
    wait_y(456, 400, n);
    chk("fall_cycles", n, 208);
    chk("ground_pre_state", state, 1);
    chk("ground_pre_crash", crash, 0);
    cyc(1);
    chk("ground_state", state, 2);
    chk("ground_crash", crash, 1);
    chk("ground_y", bird_Y, 456);
    chk("ground_vel", bird_vel, 8);
    cyc(1);
    chk("crash_one_cycle", crash, 0);
    chk("over_hold_state", state, 2);

    // Lockout: early flap and the last discarded flap (counter 249), then accepted one.
    cyc(99);
    btn_flap = 1'b1;
    cyc(4);
    chk("early_flap_state", state, 2);
    btn_flap = 1'b0;
    cyc(143);
    btn_flap = 1'b1;
    cyc(3);
    chk("lock249_state", state, 2);
    btn_flap = 1'b0;
    cyc(3);
    btn_flap = 1'b1;
    cyc(2);
    chk("lock_pre_state", state, 2);
    cyc(1);
    chk("lock_done_state", state, 0);
    chk("lock_done_y", bird_Y, 228);
    chk("lock_done_vel", bird_vel, 0);
    btn_flap = 1'b0;

    // Game D: reset in the middle of play.
    cyc(2);
    btn_flap = 1'b1;
    cyc(3);
    chk("gameD_state", state, 1);
    btn_flap = 1'b0;
    cyc(10);
    chk("gameD_y", bird_Y, 222);
    pulse_rst();
    chk("midrst_state", state, 0);
    chk("midrst_y", bird_Y, 228);
    chk("midrst_vel", bird_vel, 0);
    chk("midrst_crash", crash, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
